// File: rtl/calc_didactic_pkg.sv
// Shared definitions for the bus transfer controller: unit codes,
// FSM state encoding, transfer record layout and request helpers.
package calc_didactic;

  // Source unit codes (bit index into src_oe)
  localparam logic [2:0] SRC_ALU    = 3'd0;
  localparam logic [2:0] SRC_RAM    = 3'd1;
  localparam logic [2:0] SRC_IO     = 3'd2;
  localparam logic [2:0] SRC_REGS   = 3'd3;
  localparam logic [2:0] SRC_CP     = 3'd4;
  localparam logic [2:0] SRC_IND    = 3'd5;
  localparam logic [2:0] SRC_OFFSET = 3'd6;
  localparam logic [2:0] SRC_INV    = 3'd7;

  // Destination unit codes (bit index into dst_ld)
  localparam logic [3:0] DST_AM   = 4'd0;
  localparam logic [3:0] DST_AIE  = 4'd1;
  localparam logic [3:0] DST_T1   = 4'd2;
  localparam logic [3:0] DST_T2   = 4'd3;
  localparam logic [3:0] DST_RI   = 4'd4;
  localparam logic [3:0] DST_RAM  = 4'd5;
  localparam logic [3:0] DST_IO   = 4'd6;
  localparam logic [3:0] DST_REGS = 4'd7;
  localparam logic [3:0] DST_CP   = 4'd8;
  localparam logic [3:0] DST_IND  = 4'd9;
  localparam logic [3:0] DST_DISP = 4'd10;

  localparam int N_SRC = 7;
  localparam int N_DST = 11;

  // Slow sources get this many WAIT cycles to raise src_ready
  localparam int         TIMEOUT_CYCLES = 16;
  localparam logic [3:0] WAIT_LAST      = 4'(TIMEOUT_CYCLES - 1);

  // Queued transfer record: {src, dst}
  localparam int XFER_W = 7;

  typedef struct packed {
    logic [2:0] src;
    logic [3:0] dst;
  } xfer_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_LOAD  = 2'd3
  } xfer_state_e;

  // Request cannot be executed: unknown codes or a unit feeding itself
  function automatic logic req_is_bad(input logic [2:0] src, input logic [3:0] dst);
    logic bad;
    bad = (src == SRC_INV) || (dst > DST_DISP);
    if (src == SRC_RAM  && dst == DST_RAM)  bad = 1'b1;
    if (src == SRC_IO   && dst == DST_IO)   bad = 1'b1;
    if (src == SRC_REGS && dst == DST_REGS) bad = 1'b1;
    if (src == SRC_CP   && dst == DST_CP)   bad = 1'b1;
    if (src == SRC_IND  && dst == DST_IND)  bad = 1'b1;
    return bad;
  endfunction

  // RAM and IO need src_ready before their data is valid on the bus
  function automatic logic src_is_slow(input logic [2:0] src);
    return (src == SRC_RAM) || (src == SRC_IO);
  endfunction

endpackage

// File: rtl/xfer_fifo.sv
// Small synchronous FIFO holding pending transfer records.
// A push while full is accepted when a pop happens in the same cycle.
module xfer_fifo
  import calc_didactic::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = XFER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Control registers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer controller: queues source->destination transfer requests
// and sequences each one as DRIVE (source enabled), optional WAIT for slow
// sources, then LOAD (destination strobe). All strobes are registered.
// Handshake: a request is taken on any cycle where req_valid and req_ready
// are both high; req_ready is high whenever the queue has a free slot.
module bus_xfer_ctrl
  import calc_didactic::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_src,
  input  logic [3:0]       req_dst,
  output logic             req_ready,
  input  logic             src_ready,
  input  logic [WIDTH-1:0] bus_in,
  output logic [6:0]       src_oe,
  output logic [10:0]      dst_ld,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] last_data
);

  xfer_state_e      state_q, state_d;
  xfer_t            cur_q, cur_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [6:0]       src_oe_q, src_oe_d;
  logic [10:0]      dst_ld_q, dst_ld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [XFER_W-1:0] fifo_dout;
  logic             req_accept, req_bad, timeout;

  assign req_ready  = !fifo_full;
  assign req_accept = req_valid && req_ready;
  assign req_bad    = req_is_bad(req_src, req_dst);
  assign fifo_push  = req_accept && !req_bad;

  xfer_fifo #(
    .DEPTH (DEPTH),
    .W     (XFER_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({req_src, req_dst}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, transfer register, timeout counter and registered strobes
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    wait_cnt_d = wait_cnt_q;
    fifo_pop   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = xfer_t'(fifo_dout);
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        wait_cnt_d = '0;
        state_d    = src_is_slow(cur_q.src) ? S_WAIT : S_LOAD;
      end
      S_WAIT: begin
        if (src_ready) begin
          state_d = S_LOAD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are computed for the state being entered so they flop in
    // alongside it; shifting a 1 keeps them one-hot by construction.
    src_oe_d = (state_d != S_IDLE) ? (7'd1 << cur_d.src) : 7'd0;
    dst_ld_d = (state_d == S_LOAD) ? (11'd1 << cur_d.dst) : 11'd0;
    done_d   = (state_q == S_LOAD);
    err_d    = (req_accept && req_bad) || timeout;
    last_d   = (state_q == S_LOAD) ? bus_in : last_q;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      wait_cnt_q <= '0;
      src_oe_q   <= '0;
      dst_ld_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      wait_cnt_q <= wait_cnt_d;
      src_oe_q   <= src_oe_d;
      dst_ld_q   <= dst_ld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  assign src_oe    = src_oe_q;
  assign dst_ld    = dst_ld_q;
  assign done      = done_q;
  assign err       = err_q;
  assign last_data = last_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Testbench for bus_xfer_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transfer-level model.
module tb_bus_xfer_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic [2:0]       req_src = '0;
  logic [3:0]       req_dst = '0;
  logic             src_ready = 1'b0;
  logic [WIDTH-1:0] bus_in = '0;
  logic             req_ready;
  logic [6:0]       src_oe;
  logic [10:0]      dst_ld;
  logic             done, err, busy;
  logic [WIDTH-1:0] last_data;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .src_ready (src_ready),
    .bus_in    (bus_in),
    .src_oe    (src_oe),
    .dst_ld    (dst_ld),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .last_data (last_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending transfers as a plain queue; the active transfer is described by
  // how many cycles it has been on the bus and how many wait cycles elapsed.
  logic [6:0]       mq[$];
  bit               m_active = 0, m_load = 0;
  logic [2:0]       m_src;
  logic [3:0]       m_dst;
  int               m_age, m_waits;
  logic [6:0]       e_src_oe;
  logic [10:0]      e_dst_ld;
  logic             e_done, e_err, e_busy, e_ready;
  logic [WIDTH-1:0] e_last;

  function automatic bit tb_bad(input logic [2:0] s, input logic [3:0] d);
    // same-unit pairs are the source codes 1..5 with destination code s+4
    return (s == 3'd7) || (d > 4'd10) || (s >= 3'd1 && s <= 3'd5 && int'(d) == int'(s) + 4);
  endfunction

  always @(posedge clk) begin : model_blk
    bit         n_err, acc, bad;
    logic [6:0] head;
    if (reset) begin
      mq.delete();
      m_active = 0; m_load = 0;
      e_src_oe = '0; e_dst_ld = '0; e_done = 0; e_err = 0;
      e_busy = 0; e_ready = 1; e_last = '0;
    end else begin
      acc    = req_valid && e_ready;
      bad    = tb_bad(req_src, req_dst);
      n_err  = acc && bad;
      e_done = (e_dst_ld != 0);
      if (e_done) e_last = bus_in;
      if (m_active) begin
        if (m_load) begin
          m_active = 0; m_load = 0;
        end else if (m_age == 0) begin
          if (!(m_src == 3'd1 || m_src == 3'd2)) m_load = 1;
        end else begin
          if (src_ready) m_load = 1;
          else begin
            m_waits++;
            if (m_waits == 16) begin m_active = 0; n_err = 1; end
          end
        end
        m_age++;
      end else if (mq.size() > 0) begin
        head = mq.pop_front();
        m_src = head[6:4]; m_dst = head[3:0];
        m_active = 1; m_load = 0; m_age = 0; m_waits = 0;
      end
      if (acc && !bad) mq.push_back({req_src, req_dst});
      e_err    = n_err;
      e_src_oe = m_active ? (7'd1 << m_src) : 7'd0;
      e_dst_ld = (m_active && m_load) ? (11'd1 << m_dst) : 11'd0;
      e_busy   = m_active || (mq.size() > 0);
      e_ready  = (mq.size() < DEPTH);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_src_oe", src_oe, e_src_oe);
      check("cyc_dst_ld", dst_ld, e_dst_ld);
      check("cyc_done", done, e_done);
      check("cyc_err", err, e_err);
      check("cyc_busy", busy, e_busy);
      check("cyc_req_ready", req_ready, e_ready);
      check("cyc_last_data", last_data, e_last);
      check("cyc_onehot", {$onehot0(src_oe), $onehot0(dst_ld)}, 2'b11);
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; src_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] s, input logic [3:0] d);
    req_valid = 1'b1; req_src = s; req_dst = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_req(input logic [2:0] s, input logic [3:0] d, output bit ok);
    req_valid = 1'b1; req_src = s; req_dst = d; ok = 0;
    for (int n = 0; n < 60; n++) begin
      if (req_ready) begin ok = 1; step(); break; end
      step();
    end
    req_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_src_oe"}, src_oe, 0);
    check({tag, "_dst_ld"}, dst_ld, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int d0;
    do_reset();
    chk_en = 1'b1;
    check_idle_outputs("rst");
    check("rst_last", last_data, 0);

    // CP -> RI, fast source: accept c0, DRIVE c2, LOAD c3, done c4
    bus_in = 16'h0102;
    issue(3'd4, 4'd4);                           // now cycle 1
    check("cp_c1_src_oe", src_oe, 0);
    check("cp_c1_busy", busy, 1);
    step();                                      // cycle 2
    check("cp_c2_src_oe", src_oe, 7'b0010000);
    check("cp_c2_dst_ld", dst_ld, 0);
    step();                                      // cycle 3
    check("cp_c3_src_oe", src_oe, 7'b0010000);
    check("cp_c3_dst_ld", dst_ld, 11'h010);
    step();                                      // cycle 4
    check("cp_c4_done", done, 1);
    check("cp_c4_dst_ld", dst_ld, 0);
    check("cp_c4_last", last_data, 16'h0102);
    step();
    check("cp_c5_done", done, 0);

    // RAM -> T1, src_ready low for 5 WAIT cycles then high
    bus_in = '0;
    issue(3'd1, 4'd2);                           // cycle 1
    step();                                      // cycle 2 DRIVE
    check("ram_drive_src_oe", src_oe, 7'b0000010);
    for (int i = 0; i < 5; i++) begin            // cycles 3..7 WAIT
      step();
      check("ram_wait_src_oe", src_oe, 7'b0000010);
      check("ram_wait_dst_ld", dst_ld, 0);
    end
    step();                                      // cycle 8 WAIT, ready high
    src_ready = 1'b1; bus_in = 16'hBEEF;
    check("ram_c8_dst_ld", dst_ld, 0);
    step();                                      // cycle 9 LOAD
    src_ready = 1'b0;
    check("ram_load_dst_ld", dst_ld, 11'h004);
    check("ram_load_src_oe", src_oe, 7'b0000010);
    step();                                      // cycle 10
    check("ram_done", done, 1);
    check("ram_last", last_data, 16'hBEEF);

    // IO -> AM with no src_ready: 16 WAIT cycles then err
    step();
    issue(3'd2, 4'd0);                           // cycle 1
    step();                                      // cycle 2
    for (int i = 0; i < 16; i++) begin           // cycles 3..18
      step();
      check("io_wait_dst_ld", dst_ld, 0);
      check("io_wait_err", err, 0);
    end
    step();                                      // cycle 19
    check("io_timeout_err", err, 1);
    check("io_timeout_busy", busy, 0);
    check("io_timeout_src_oe", src_oe, 0);
    step();
    check("io_err_pulse", err, 0);

    // Hold the engine in WAIT, then push 5 requests; the 5th must stall
    d0 = done_cnt;
    push_req(3'd1, 4'd3, ok);  check("q_slow_acc", ok, 1);
    push_req(3'd0, 4'd2, ok);  check("q1_acc", ok, 1);
    push_req(3'd3, 4'd3, ok);  check("q2_acc", ok, 1);
    push_req(3'd4, 4'd0, ok);  check("q3_acc", ok, 1);
    push_req(3'd6, 4'd10, ok); check("q4_acc", ok, 1);
    check("q_full_ready", req_ready, 0);
    fork
      begin push_req(3'd5, 4'd1, ok); check("q5_acc", ok, 1); end
      begin repeat (6) step(); src_ready = 1'b1; step(); src_ready = 1'b0; end
    join
    for (int k = 0; k < 200 && busy; k++) step();
    step();
    check("q_drain_busy", busy, 0);
    check("q_done_count", done_cnt - d0, 6);

    // Invalid source, then a same-unit pair: two err pulses, nothing queued
    issue(3'd7, 4'd0);                           // cycle 1
    req_valid = 1'b1; req_src = 3'd3; req_dst = 4'd7;
    check("bad1_err", err, 1);
    step();
    req_valid = 1'b0;
    check("bad2_err", err, 1);
    check("bad2_src_oe", src_oe, 0);
    step();
    check("bad_after_err", err, 0);
    check("bad_after_busy", busy, 0);
    check("bad_after_src_oe", src_oe, 0);

    // Reset while in WAIT drops the transfer silently
    d0 = done_cnt + err_cnt;
    issue(3'd1, 4'd0);
    step(); step();                              // cycle 3 WAIT
    check("rw_in_wait_src_oe", src_oe, 7'b0000010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("rw");
    repeat (20) step();
    check("rw_no_pulses", done_cnt + err_cnt - d0, 0);
    check("rw_still_idle", busy, 0);

    // Randomized traffic
    for (int blk = 0; blk < 16; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 4 == 3) ? 0 : int'($urandom_range(10, 80));
      for (int c = 0; c < 100; c++) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_src   = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        req_dst   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                                : 4'($urandom_range(0, 10));
        src_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        bus_in    = 16'($urandom);
        reset     = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    reset = 1'b0; req_valid = 1'b0; src_ready = 1'b1;
    for (int k = 0; k < 300 && busy; k++) step();
    step();
    check("final_busy", busy, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
